seg7_byte_decoder: RTL and testbench
====================================

SEG7_BYTE_DECODER -- requirements
Module: seg7_byte_decoder

Interface
REQ-001 The block SHALL have parameter ACTIVE_LOW, default 1, meaning segment polarity (1: lit segment = 0, 0: lit segment = 1).
REQ-002 The block SHALL have port clk, input, 1 bit, system clock, rising-edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-004 The block SHALL have port seg_in, input, 21 bits, display word: [6:0] ones digit, [13:7] tens digit, [20:14] hundreds digit, each in {g,f,e,d,c,b,a} order with bit 6 = g.
REQ-005 The block SHALL have port in_valid, input, 1 bit, seg_in is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, the block accepts seg_in.
REQ-007 The block SHALL have port byte_out, output, 8 bits, recovered binary byte.
REQ-008 The block SHALL have port err_out, output, 2 bits: bit0 err_seg (illegal pattern), bit1 err_range (value >255).
REQ-009 The block SHALL have port out_valid, output, 1 bit, byte_out and err_out are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the consumer accepts the result.

Function
REQ-011 Legal patterns with ACTIVE_LOW=1 SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; with ACTIVE_LOW=0, each is bitwise inverted.
REQ-012 The FSM SHALL have states IDLE, DECODE, CONVERT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 In IDLE, in_valid=1 SHALL register seg_in at the clock edge (edge E0) and move to DECODE.
REQ-014 DECODE SHALL take 1 cycle: the three digits map to a 12-bit BCD register; any illegal digit sets err_seg and goes to DONE with byte_out=0; otherwise it clears the 4-bit iteration counter and goes to CONVERT.
REQ-015 CONVERT SHALL run reverse double-dabble for exactly 10 cycles: shift {bcd[11:0], bin[9:0]} right by 1, then subtract 3 from each BCD nibble that is >=8; after the 10th iteration it goes to DONE.
REQ-016 Result rules: bin <=255 gives byte_out=bin[7:0] and err_out=00; bin >255 gives byte_out=8'hFF and err_range=1.
REQ-017 Latency: out_valid SHALL rise after edge E0+11 on a legal input, or after edge E0+2 on err_seg; there SHALL be no pipelining (one conversion in flight).
REQ-018 In DONE, out_valid=1 and outputs SHALL hold stable until out_ready=1 at an edge; the block then returns to IDLE with out_valid=0.
REQ-019 out_ready is ignored outside DONE; in_valid is ignored outside IDLE; the earliest next accept SHALL be 1 cycle after the DONE handshake.
REQ-020 byte_out and err_out SHALL keep their last values after the handshake until the next DONE.

Reset
REQ-021 reset=1 SHALL asynchronously force IDLE, out_valid=0, byte_out=8'h00, err_out=00, and clear the BCD, binary and counter registers.
REQ-022 Reset asserted in any state, including mid-CONVERT, SHALL abort the conversion with no out_valid pulse; in_ready=1 from the first edge after release.

Configuration
REQ-023 Macro SEG7_DEC_BLANK_ZERO_EN SHALL control blank-digit handling.
REQ-024 With the macro defined, an all-off pattern (1111111 when ACTIVE_LOW=1) SHALL decode as 0 in the hundreds digit, and in the tens digit only if the hundreds digit is also blank; a blank ones digit is still err_seg.
REQ-025 Without the macro, any blank digit SHALL be err_seg.

Verification
REQ-026 Digits 1,5,1 (hundreds..ones) accepted at E0 -> out_valid after E0+11, byte_out=8'h97, err_out=00.
REQ-027 Digits 2,5,5 -> byte_out=8'hFF, err_out=00; digits 9,9,9 -> byte_out=8'hFF, err_out=10.
REQ-028 Ones pattern 1111110 -> out_valid after E0+2, byte_out=8'h00, err_out=01.
REQ-029 out_ready held 0 for 5 cycles in DONE -> byte_out, err_out and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-030 reset pulsed at E0+5 -> out_valid stays 0; a following input with digits 0,4,2 -> byte_out=8'h2A.
REQ-031 Digits blank,blank,7 -> byte_out=8'h07, err_out=00 with SEG7_DEC_BLANK_ZERO_EN; err_out=01 without.

Source files
------------

// File: rtl/seg7_byte_decoder.sv
// rtl/seg7_byte_decoder.sv - three-digit seven-segment word to binary byte decoder
// Optional build macro: SEG7_DEC_BLANK_ZERO_EN (leading blank digits read as zero)
module seg7_byte_decoder #(
  parameter int ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [20:0] seg_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  byte_out,
  output logic [1:0]  err_out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, DECODE, CONVERT, DONE} state_t;

  state_t      state_q, state_d;
  logic [20:0] seg_q, seg_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic [1:0]  err_q, err_d;
  logic        valid_q, valid_d;
  logic        pend_q, pend_d;

  // Returns {blank, illegal, digit}; patterns are compared in active-low form.
  function automatic logic [5:0] seg_lookup(input logic [6:0] pat);
    logic [6:0] p;
    p = (ACTIVE_LOW != 0) ? pat : ~pat;
    case (p)
      7'b1000000: seg_lookup = 6'b00_0000;
      7'b1111001: seg_lookup = 6'b00_0001;
      7'b0100100: seg_lookup = 6'b00_0010;
      7'b0110000: seg_lookup = 6'b00_0011;
      7'b0011001: seg_lookup = 6'b00_0100;
      7'b0010010: seg_lookup = 6'b00_0101;
      7'b0000010: seg_lookup = 6'b00_0110;
      7'b1111000: seg_lookup = 6'b00_0111;
      7'b0000000: seg_lookup = 6'b00_1000;
      7'b0010000: seg_lookup = 6'b00_1001;
      7'b1111111: seg_lookup = 6'b10_0000;
      default:    seg_lookup = 6'b01_0000;
    endcase
  endfunction

  // Reverse double-dabble correction: a nibble that received a shifted-in
  // weight of 8 is really worth 5, so take 3 back out.
  function automatic logic [3:0] nib_adj(input logic [3:0] n);
    nib_adj = (n >= 4'd8) ? n - 4'd3 : n;
  endfunction

  logic [5:0]  lk_h, lk_t, lk_o;
  logic        bad_h, bad_t, bad_o;
  logic [21:0] shifted;

  // Per-digit lookup and legality, including the optional leading-blank rule.
  always_comb begin
    lk_h = seg_lookup(seg_q[20:14]);
    lk_t = seg_lookup(seg_q[13:7]);
    lk_o = seg_lookup(seg_q[6:0]);
`ifdef SEG7_DEC_BLANK_ZERO_EN
    bad_h = lk_h[4];
    bad_t = lk_t[4] | (lk_t[5] & ~lk_h[5]);
    bad_o = lk_o[4] | lk_o[5];
`else
    bad_h = lk_h[4] | lk_h[5];
    bad_t = lk_t[4] | lk_t[5];
    bad_o = lk_o[4] | lk_o[5];
`endif
    shifted = {bcd_q, bin_q} >> 1;
  end

  // Next-state and datapath update for the four-state controller.
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    err_d   = err_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          seg_d   = seg_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        bcd_d = {lk_h[3:0], lk_t[3:0], lk_o[3:0]};
        bin_d = 10'd0;
        cnt_d = 4'd0;
        if (bad_h | bad_t | bad_o) begin
          pend_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        bcd_d = {nib_adj(shifted[21:18]), nib_adj(shifted[17:14]), nib_adj(shifted[13:10])};
        bin_d = shifted[9:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          if (shifted[9:0] > 10'd255) begin
            byte_d = 8'hFF;
            err_d  = 2'b10;
          end else begin
            byte_d = shifted[7:0];
            err_d  = 2'b00;
          end
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (pend_q) begin
          // Illegal-pattern result is presented one cycle after DECODE.
          byte_d  = 8'h00;
          err_d   = 2'b01;
          valid_d = 1'b1;
          pend_d  = 1'b0;
        end else if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      seg_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign byte_out  = byte_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_seg7_byte_decoder.sv
// tb/tb_seg7_byte_decoder.sv - directed self-checking bench for seg7_byte_decoder
module tb_seg7_byte_decoder;

  logic        clk;
  logic        reset;
  logic [20:0] seg_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  byte_out;
  logic [1:0]  err_out;
  logic        out_valid;
  logic        out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  seg7_byte_decoder #(.ACTIVE_LOW(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .byte_out  (byte_out),
    .err_out   (err_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = BLANK;
    endcase
  endfunction

  function automatic logic [20:0] word(input int h, input int t, input int o);
    word = {seg_of(h), seg_of(t), seg_of(o)};
  endfunction

  task automatic start_word(input logic [20:0] w);
    @(negedge clk);
    seg_in   = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    n_tests++;
    if (byte_out !== 8'h00 || err_out !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_data: byte=%h err=%b, required 00/00", byte_out, err_out);
    end
  endtask

  task automatic test_values;
    int         vh [7] = '{1, 2, 9, 2, 0, 0, 2};
    int         vt [7] = '{5, 5, 9, 5, 0, 4, 5};
    int         vo [7] = '{1, 5, 9, 6, 0, 2, 4};
    logic [7:0] eb [7] = '{8'h97, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h2A, 8'hFE};
    logic [1:0] ee [7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 7; i++) begin
      start_word(word(vh[i], vt[i], vo[i]));
      wait_edges(10);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL early_valid[%0d]: out_valid=%b at E0+10, required 0", i, out_valid);
      end
      wait_edges(1);
      n_tests++;
      if (out_valid !== 1'b1 || byte_out !== eb[i] || err_out !== ee[i]) begin
        n_fail++;
        $display("FAIL value[%0d]: valid=%b byte=%h err=%b, required 1/%h/%b",
                 i, out_valid, byte_out, err_out, eb[i], ee[i]);
      end
      ack();
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL release[%0d]: valid=%b in_ready=%b, required 0/1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_err_seg;
    start_word({seg_of(0), seg_of(0), 7'b1111110});
    wait_edges(1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_early: out_valid=%b at E0+1, required 0", out_valid);
    end
    wait_edges(1);
    n_tests++;
    if (out_valid !== 1'b1 || byte_out !== 8'h00 || err_out !== 2'b01) begin
      n_fail++;
      $display("FAIL err_seg: valid=%b byte=%h err=%b, required 1/00/01", out_valid, byte_out, err_out);
    end
    ack();
  endtask

  task automatic test_hold;
    start_word(word(1, 2, 8));
    wait_edges(11);
    @(negedge clk);
    seg_in   = word(3, 3, 3);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      wait_edges(1);
      n_tests++;
      if (out_valid !== 1'b1 || byte_out !== 8'h80 || err_out !== 2'b00 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: valid=%b byte=%h err=%b in_ready=%b, required 1/80/00/0",
                 c, out_valid, byte_out, err_out, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    ack();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || byte_out !== 8'h80 || err_out !== 2'b00) begin
      n_fail++;
      $display("FAIL after_ack: valid=%b in_ready=%b byte=%h err=%b, required 0/1/80/00",
               out_valid, in_ready, byte_out, err_out);
    end
  endtask

  task automatic test_reset_abort;
    logic seen;
    start_word(word(1, 5, 1));
    wait_edges(4);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    #1;
    n_tests++;
    if (byte_out !== 8'h00 || err_out !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_clear: byte=%h err=%b, required 00/00", byte_out, err_out);
    end
    wait_edges(1);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready: in_ready=%b, required 1", in_ready);
    end
    for (int c = 0; c < 12; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      wait_edges(1);
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_valid: out_valid pulsed=%b, required 0", seen);
    end
    start_word(word(0, 4, 2));
    wait_edges(11);
    n_tests++;
    if (out_valid !== 1'b1 || byte_out !== 8'h2A || err_out !== 2'b00) begin
      n_fail++;
      $display("FAIL post_abort: valid=%b byte=%h err=%b, required 1/2A/00", out_valid, byte_out, err_out);
    end
    ack();
  endtask

  task automatic run_blank(input string name, input logic [20:0] w,
                           input int exp_lat, input logic [7:0] exp_b, input logic [1:0] exp_e);
    int lat;
    start_word(w);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      wait_edges(1);
      lat++;
    end
    n_tests++;
    if (lat !== exp_lat || byte_out !== exp_b || err_out !== exp_e) begin
      n_fail++;
      $display("FAIL %s: latency=%0d byte=%h err=%b, required %0d/%h/%b",
               name, lat, byte_out, err_out, exp_lat, exp_b, exp_e);
    end
    if (out_valid === 1'b1) ack();
  endtask

  task automatic test_blank;
`ifdef SEG7_DEC_BLANK_ZERO_EN
    run_blank("blank_blank_7", {BLANK, BLANK, seg_of(7)}, 11, 8'h07, 2'b00);
`else
    run_blank("blank_blank_7", {BLANK, BLANK, seg_of(7)}, 2, 8'h00, 2'b01);
`endif
    run_blank("tens_blank_only", {seg_of(1), BLANK, seg_of(5)}, 2, 8'h00, 2'b01);
    run_blank("ones_blank", {BLANK, BLANK, BLANK}, 2, 8'h00, 2'b01);
  endtask

  initial begin
    reset     = 1'b1;
    seg_in    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_values();
    test_err_seg();
    test_hold();
    test_reset_abort();
    test_blank();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
